// File: rtl/bu_ct_combine_pkg.sv
// Shared constants for the butterfly-unit combine stage: beat mode encoding
// and the default multiplier latencies the delay line must match.
package bu_ct_combine_pkg;

  // Beat mode: CT butterfly (u+t / u-t) or pass-through for pointwise multiply.
  typedef enum logic {
    BU_MODE_CT   = 1'b0,
    BU_MODE_PASS = 1'b1
  } bu_mode_e;

  // Pipeline depths of the modmul building blocks.
  localparam int INTMUL_LAT_32 = 3;
  localparam int INTMUL_LAT_64 = 4;
  localparam int MODRED_CC_32  = 3;
  localparam int MODRED_CC_64  = 4;

  // Default modmul latency (integer multiply followed by modular reduction).
  localparam int BU_MUL_LAT_32 = INTMUL_LAT_32 + MODRED_CC_32;
  localparam int BU_MUL_LAT_64 = INTMUL_LAT_64 + MODRED_CC_64;

endpackage

// File: rtl/bu_ct_combine_if.sv
// Beat bus between the butterfly controller, modmul and the combine stage.
//
// Handshake: there is no ready. in_valid is a one-cycle issue strobe; every
// edge that samples in_valid=1 accepts one beat {q, in_u, in_mode, in_tag},
// and that beat is presented exactly once, in order, as a one-cycle out_valid
// strobe MUL_LAT+1 edges later. mul_res must carry the beat's product in the
// cycle after edge E(MUL_LAT). out_x/out_y/out_tag hold their last values
// while out_valid is low.
interface bu_ct_combine_if #(
  parameter int LOGQ  = 32,
  parameter int TAG_W = 12,
  parameter int CNT_W = 3
);
  logic [LOGQ-1:0]  q;
  logic             in_valid;
  logic [LOGQ-1:0]  in_u;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic [LOGQ-1:0]  mul_res;
  logic             out_valid;
  logic [LOGQ-1:0]  out_x;
  logic [LOGQ-1:0]  out_y;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] inflight;
  logic             busy;

  // Controller side: issues beats, consumes results.
  modport master (
    output q, in_valid, in_u, in_mode, in_tag, mul_res,
    input  out_valid, out_x, out_y, out_tag, inflight, busy
  );

  // Combine-stage side.
  modport slave (
    input  q, in_valid, in_u, in_mode, in_tag, mul_res,
    output out_valid, out_x, out_y, out_tag, inflight, busy
  );
endinterface

// File: rtl/bu_ct_combine_modaddsub.sv
// Registered LOGQ-bit modular add/sub with a pass-through select.
// One conditional correction per result: fully reduced for u, t < q.
module bu_ct_combine_modaddsub
  import bu_ct_combine_pkg::*;
#(
  parameter int LOGQ  = 32,
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LOGQ-1:0]  u,
  input  logic [LOGQ-1:0]  t,
  input  logic [LOGQ-1:0]  q,
  input  bu_mode_e         mode,
  input  logic [TAG_W-1:0] beat_tag,
  output logic             res_valid,
  output logic [LOGQ-1:0]  res_x,
  output logic [LOGQ-1:0]  res_y,
  output logic [TAG_W-1:0] res_tag
);

  logic [LOGQ:0]   sum;
  logic [LOGQ:0]   diff;
  logic [LOGQ-1:0] nxt_x;
  logic [LOGQ-1:0] nxt_y;

  // Add/sub at LOGQ+1 bits, then one conditional correction each. The
  // corrections are done modulo 2^LOGQ, which is exact for the kept bits.
  always_comb begin
    sum   = {1'b0, u} + {1'b0, t};
    diff  = {1'b0, u} - {1'b0, t};
    nxt_x = sum[LOGQ-1:0];
    nxt_y = diff[LOGQ-1:0];
    if (mode == BU_MODE_PASS) begin
      nxt_x = u;
      nxt_y = t;
    end else begin
      if (sum >= {1'b0, q}) nxt_x = sum[LOGQ-1:0] - q;
      if (diff[LOGQ])       nxt_y = diff[LOGQ-1:0] + q;
    end
  end

  // Result strobe follows the load; data registers hold between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      res_tag   <= '0;
    end else begin
      res_valid <= load;
      if (load) begin
        res_x   <= nxt_x;
        res_y   <= nxt_y;
        res_tag <= beat_tag;
      end
    end
  end

endmodule

// File: rtl/bu_ct_combine.sv
// Cooley-Tukey butterfly combine: delays {u, q, mode, tag} to meet the
// modmul product t, then emits x = u+t mod q and y = u-t mod q.
module bu_ct_combine
  import bu_ct_combine_pkg::*;
#(
  parameter int LOGQ    = 32,
  parameter int MUL_LAT = BU_MUL_LAT_32,
  parameter int TAG_W   = 12,
  parameter int CNT_W   = $clog2(MUL_LAT + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  bu_ct_combine_if.slave   bus
);

  // The issue edge E0 captures the beat into entry 0; the product is sampled
  // by the combine register at E(MUL_LAT+1), so the beat must be in the last
  // entry after E(MUL_LAT): MUL_LAT+1 entries including the capture entry.
  localparam int DEPTH = MUL_LAT + 1;

  logic [DEPTH-1:0] dl_valid;
  logic [LOGQ-1:0]  dl_u    [DEPTH];
  logic [LOGQ-1:0]  dl_q    [DEPTH];
  bu_mode_e         dl_mode [DEPTH];
  logic [TAG_W-1:0] dl_tag  [DEPTH];
  logic [CNT_W-1:0] inflight;
  logic             retire;

  assign retire = dl_valid[DEPTH-1];

  // Resettable valid chain: reset discards every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dl_valid <= '0;
    else        dl_valid <= {dl_valid[DEPTH-2:0], bus.in_valid};
  end

  // Data shift register, no enable and no reset; only the valid chain
  // decides whether an entry means anything.
  always_ff @(posedge clk) begin
    dl_u[0]    <= bus.in_u;
    dl_q[0]    <= bus.q;
    dl_mode[0] <= bu_mode_e'(bus.in_mode);
    dl_tag[0]  <= bus.in_tag;
    for (int k = 1; k < DEPTH; k++) begin
      dl_u[k]    <= dl_u[k-1];
      dl_q[k]    <= dl_q[k-1];
      dl_mode[k] <= dl_mode[k-1];
      dl_tag[k]  <= dl_tag[k-1];
    end
  end

  // In-flight count: up on issue, down when the combine register takes a
  // beat; bounded by DEPTH so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({bus.in_valid, retire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign bus.inflight = inflight;
  assign bus.busy     = (inflight != '0);

  bu_ct_combine_modaddsub #(
    .LOGQ  (LOGQ),
    .TAG_W (TAG_W)
  ) u_modaddsub (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (retire),
    .u         (dl_u[DEPTH-1]),
    .t         (bus.mul_res),
    .q         (dl_q[DEPTH-1]),
    .mode      (dl_mode[DEPTH-1]),
    .beat_tag  (dl_tag[DEPTH-1]),
    .res_valid (bus.out_valid),
    .res_x     (bus.out_x),
    .res_y     (bus.out_y),
    .res_tag   (bus.out_tag)
  );

endmodule

// File: tb/tb_bu_ct_combine.sv
// Bench for bu_ct_combine: randomized beats against a modular-arithmetic
// reference with an expected queue keyed by the edge each result is due.
module tb_bu_ct_combine;
  import bu_ct_combine_pkg::*;

  localparam int LOGQ    = 32;
  localparam int MUL_LAT = 6;
  localparam int TAG_W   = 12;
  localparam int CNT_W   = $clog2(MUL_LAT + 2);
  localparam int EW      = 32 + 2 * LOGQ + TAG_W;

  logic clk;
  logic rst_n;

  bu_ct_combine_if #(.LOGQ(LOGQ), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  bu_ct_combine #(
    .LOGQ    (LOGQ),
    .MUL_LAT (MUL_LAT),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- scoreboard state ----------------
  // entry = {due edge, x, y, tag}
  logic [EW-1:0]    exp_q[$];
  logic [LOGQ-1:0]  prod [int];
  logic [LOGQ-1:0]  last_x, last_y;
  logic [TAG_W-1:0] last_tag;
  int               n_tests = 0;
  int               n_fail  = 0;
  int               peak    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edge_n, got, exp);
    end
  endtask

  // Reference: x = (u+t) mod q, y = (u-t) mod q; pass-through returns u, t.
  function automatic logic [2*LOGQ-1:0] ref_xy(input logic [LOGQ-1:0] u, input logic [LOGQ-1:0] t,
                                              input logic [LOGQ-1:0] qq, input logic mode);
    longint lu, lt, lq;
    lu = u; lt = t; lq = qq;
    if (mode) return {u, t};
    return {LOGQ'((lu + lt) % lq), LOGQ'((lu - lt + lq) % lq)};
  endfunction

  // Called on a falling edge: compares everything the DUT shows after edge edge_n.
  task automatic check_outputs();
    logic [EW-1:0] e;
    bit            exp_v;
    exp_v = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      exp_v = (int'(e[EW-1 -: 32]) == edge_n);
    end
    check("out_valid", bus.out_valid, exp_v);
    if (exp_v) begin
      void'(exp_q.pop_front());
      last_x   = e[EW-33 -: LOGQ];
      last_y   = e[EW-33-LOGQ -: LOGQ];
      last_tag = e[TAG_W-1:0];
      check("out_x", bus.out_x, last_x);
      check("out_y", bus.out_y, last_y);
      check("out_tag", bus.out_tag, last_tag);
    end else begin
      check("held_x", bus.out_x, last_x);
      check("held_y", bus.out_y, last_y);
      check("held_tag", bus.out_tag, last_tag);
    end
    check("inflight", bus.inflight, exp_q.size());
    check("busy", bus.busy, exp_q.size() != 0);
    if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [LOGQ-1:0] u, input logic [LOGQ-1:0] t,
                      input logic [LOGQ-1:0] qq, input logic mode, input logic [TAG_W-1:0] tag);
    int due;
    @(negedge clk);
    check_outputs();
    bus.in_valid = v;
    bus.in_u     = u;
    bus.q        = qq;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    if (v) begin
      due = edge_n + 1 + MUL_LAT + 1;
      prod[due] = t;
      exp_q.push_back({32'(due), ref_xy(u, t, qq, mode), tag});
    end
    // modmul model: product visible in the cycle before its due edge, noise otherwise
    bus.mul_res = prod.exists(edge_n + 1) ? prod[edge_n + 1] : LOGQ'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, LOGQ'($urandom), '0, LOGQ'($urandom), 1'b0, '0);
  endtask

  task automatic rand_beat(input logic [TAG_W-1:0] tag);
    logic [LOGQ-1:0] qq, u, t;
    logic            mode;
    qq   = LOGQ'($urandom_range(32'hFFFF_FFFF, 2));
    u    = LOGQ'($urandom % qq);
    mode = ($urandom_range(0, 3) == 0);
    t    = mode ? LOGQ'($urandom) : LOGQ'($urandom % qq);
    step(1'b1, u, t, qq, mode, tag);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    check_outputs();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_x", bus.out_x, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_inflight", bus.inflight, 0);
    check("rst_busy", bus.busy, 0);
    exp_q.delete();
    last_x = '0; last_y = '0; last_tag = '0;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    bus.mul_res = LOGQ'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_u = '0; bus.q = '0; bus.in_mode = 1'b0; bus.in_tag = '0; bus.mul_res = '0;
    last_x = '0; last_y = '0; last_tag = '0;
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // single CT beat, latency and basic reduction
    step(1'b1, 32'd5, 32'd7, 32'd12289, BU_MODE_CT, 12'd1);
    idle(10);

    // reduction corners
    step(1'b1, 32'd12000, 32'd1000, 32'd12289, BU_MODE_CT, 12'd2);
    step(1'b1, 32'd0, 32'd0, 32'd12289, BU_MODE_CT, 12'd3);
    step(1'b1, 32'd12288, 32'd1, 32'd12289, BU_MODE_CT, 12'd4);
    idle(10);

    // 16 back-to-back beats, steady in-flight count
    peak = 0;
    for (int i = 0; i < 16; i++)
      step(1'b1, LOGQ'($urandom % 12289), LOGQ'($urandom % 12289), 32'd12289, BU_MODE_CT, TAG_W'(i));
    idle(12);
    check("inflight_peak", peak, MUL_LAT + 1);

    // pass-through and per-beat modulus change
    step(1'b1, 32'd3, 32'd99999, 32'd12289, BU_MODE_PASS, 12'd20);
    step(1'b1, 32'd100, 32'd200, 32'd12289, BU_MODE_CT, 12'd21);
    step(1'b1, 32'd10, 32'd12, 32'd17, BU_MODE_CT, 12'd22);
    step(1'b1, 32'd16, 32'd16, 32'd17, BU_MODE_CT, 12'd23);
    idle(10);

    // random stream with random gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) rand_beat(TAG_W'($urandom));
      else idle(1);
    end
    idle(10);

    // reset with four beats in flight, then one fresh beat
    for (int i = 0; i < 4; i++) rand_beat(TAG_W'(100 + i));
    idle(1);
    reset_pulse();
    idle(3);
    step(1'b1, 32'd7, 32'd9, 32'd12289, BU_MODE_CT, 12'd77);
    idle(10);

    // bounded drain
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
    check("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
